// File: rtl/amount_entry_encoder.sv
// amount_entry_encoder
//   Keypad/switch front end: turns debounced decimal digit presses into a
//   32-bit binary amount (value = value*10 + digit), with backspace, clear
//   and enter. Enter emits a one-cycle commit strobe with the latched amount.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   sw_digit      digit value on switches (synchronized, sampled at event)
//   btn_digit     raw button: append sw_digit
//   btn_back      raw button: delete last digit
//   btn_clear     raw button: clear entry
//   btn_enter     raw button: commit entry
//   entry_value   live binary value of the digits entered so far
//   digit_count   number of digits currently held
//   commit_value  amount latched at last commit
//   commit_pulse  one-cycle strobe, same cycle commit_value updates
//   err_pulse     one-cycle strobe on a rejected action
//   state_out     FSM state (00 IDLE, 01 ENTRY)
//
// Press-to-output latency is DEBOUNCE_CYCLES+3 edges: 2 sync flops, the
// debounce count, and the action register. The rising-edge detect registers
// its event. It gets that extra stage for free because the debounced level
// flips on the edge that sees the last required sample.

// Per-button conditioning: 2-flop sync, debounce counter, registered rise.
module amount_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic          lvl, lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      // Release is filtered like a press but produces no event.
      rise  <= lvl & ~lvl_d;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This edge sees the DEBOUNCE_CYCLES-th consecutive differing sample.
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module amount_entry_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_DIGITS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw_digit,
  input  logic        btn_digit,
  input  logic        btn_back,
  input  logic        btn_clear,
  input  logic        btn_enter,
  output logic [31:0] entry_value,
  output logic [3:0]  digit_count,
  output logic [31:0] commit_value,
  output logic        commit_pulse,
  output logic        err_pulse,
  output logic [1:0]  state_out
);
  localparam int NUM_BTN = 4;
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ENTRY = 2'b01
  } state_t;

  // Button lanes: [0] digit, [1] back, [2] clear, [3] enter.
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] ev;

  assign btn_raw = {btn_enter, btn_clear, btn_back, btn_digit};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    amount_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .rise (ev[i])
    );
  end

  // The switches only need synchronizing. They are read at the event.
  // Their 2-flop delay matches the button path, so a value set together
  // with the press is seen.
  logic [3:0] sw_s1, sw_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_digit;
      sw_s2 <= sw_s1;
    end
  end

  state_t      state, state_n;
  logic [31:0] val_n, cval_n;
  logic [3:0]  cnt_n;
  logic        cp_n, ep_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      entry_value  <= '0;
      digit_count  <= '0;
      commit_value <= '0;
      commit_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state        <= state_n;
      entry_value  <= val_n;
      digit_count  <= cnt_n;
      commit_value <= cval_n;
      commit_pulse <= cp_n;
      err_pulse    <= ep_n;
    end
  end

  // Priority clear > enter > back > digit. Lower events in the same cycle are
  // dropped silently.
  always_comb begin
    state_n = state;
    val_n   = entry_value;
    cnt_n   = digit_count;
    cval_n  = commit_value;
    cp_n    = 1'b0;
    ep_n    = 1'b0;
    if (ev[2]) begin
      val_n   = '0;
      cnt_n   = '0;
      state_n = IDLE;
    end else if (ev[3]) begin
      if (state == ENTRY) begin
        cval_n  = entry_value;
        cp_n    = 1'b1;
        val_n   = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        ep_n = 1'b1;
      end
    end else if (ev[1]) begin
      if (state == ENTRY) begin
        val_n = entry_value / 32'd10;
        cnt_n = digit_count - 4'd1;
        if (digit_count == 4'd1) state_n = IDLE;
      end else begin
        ep_n = 1'b1;
      end
    end else if (ev[0]) begin
      if (sw_s2 > 4'd9 || digit_count == MAX_CNT) begin
        ep_n = 1'b1;
      end else begin
        // x*10 = x*8 + x*2. The digit limit keeps this below 10^9.
        val_n   = (entry_value << 3) + (entry_value << 1) + {28'd0, sw_s2};
        cnt_n   = digit_count + 4'd1;
        state_n = ENTRY;
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_amount_entry_encoder.sv
module tb_amount_entry_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw_digit = '0;
  logic        btn_digit = 1'b0, btn_back = 1'b0, btn_clear = 1'b0, btn_enter = 1'b0;
  logic [31:0] entry_value, commit_value;
  logic [3:0]  digit_count;
  logic        commit_pulse, err_pulse;
  logic [1:0]  state_out;

  int n_chk  = 0;
  int n_fail = 0;

  // Snapshots: pre = edge before the expected update, snap = update edge,
  // nxt = edge after (pulses must be gone).
  logic [31:0] pre_val, snap_val, snap_cval;
  logic [3:0]  pre_cnt, snap_cnt;
  logic [1:0]  snap_st;
  logic        pre_cp, pre_ep, snap_cp, snap_ep, nxt_cp, nxt_ep;

  amount_entry_encoder #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_digit     (sw_digit),
    .btn_digit    (btn_digit),
    .btn_back     (btn_back),
    .btn_clear    (btn_clear),
    .btn_enter    (btn_enter),
    .entry_value  (entry_value),
    .digit_count  (digit_count),
    .commit_value (commit_value),
    .commit_pulse (commit_pulse),
    .err_pulse    (err_pulse),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    {btn_enter, btn_clear, btn_back, btn_digit} = m;
  endtask

  // mask: [0] digit [1] back [2] clear [3] enter
  task automatic press(input logic [3:0] mask, input logic [3:0] d);
    sw_digit = d;
    repeat (3) @(negedge clk);
    set_btn(mask);
    repeat (7) @(posedge clk);
    #1;
    pre_val = entry_value; pre_cnt = digit_count;
    pre_cp = commit_pulse; pre_ep = err_pulse;
    @(posedge clk);
    #1;
    snap_val = entry_value; snap_cnt = digit_count; snap_cval = commit_value;
    snap_st = state_out; snap_cp = commit_pulse; snap_ep = err_pulse;
    @(posedge clk);
    #1;
    nxt_cp = commit_pulse; nxt_ep = err_pulse;
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_btn(4'b0000);
    repeat (12) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    press(4'b0001, d);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_val", entry_value, 0);
    check("rst_cnt", {28'd0, digit_count}, 0);
    check("rst_cval", commit_value, 0);
    check("rst_pulses", {30'd0, commit_pulse, err_pulse}, 0);
    check("rst_state", {30'd0, state_out}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 4, 2, 7 with exact latency
    digit(4'd4);
    check("d4_pre", pre_val, 0);
    check("d4_val", snap_val, 4);
    check("d4_cnt", {28'd0, snap_cnt}, 1);
    check("d4_state", {30'd0, snap_st}, 1);
    digit(4'd2);
    check("d2_pre", pre_val, 4);
    check("d2_val", snap_val, 42);
    check("d2_cnt", {28'd0, snap_cnt}, 2);
    digit(4'd7);
    check("d7_pre", pre_val, 42);
    check("d7_val", snap_val, 427);
    check("d7_cnt", {28'd0, snap_cnt}, 3);

    // Clear, then fill to MAX_DIGITS and overflow
    press(4'b0100, 4'd0);
    check("clr_val", snap_val, 0);
    check("clr_state", {30'd0, snap_st}, 0);
    check("clr_err", {31'd0, snap_ep}, 0);
    for (int i = 1; i <= 8; i++) digit(4'(i));
    check("fill_val", snap_val, 12345678);
    check("fill_cnt", {28'd0, snap_cnt}, 8);
    digit(4'd9);
    check("ovf_err", {31'd0, snap_ep}, 1);
    check("ovf_err_1cyc", {31'd0, nxt_ep}, 0);
    check("ovf_val", snap_val, 12345678);
    check("ovf_cnt", {28'd0, snap_cnt}, 8);
    press(4'b1000, 4'd9);
    check("ent_pre_cp", {31'd0, pre_cp}, 0);
    check("ent_cp", {31'd0, snap_cp}, 1);
    check("ent_cp_1cyc", {31'd0, nxt_cp}, 0);
    check("ent_err", {31'd0, snap_ep}, 0);
    check("ent_cval", snap_cval, 12345678);
    check("ent_val", snap_val, 0);
    check("ent_cnt", {28'd0, snap_cnt}, 0);
    check("ent_state", {30'd0, snap_st}, 0);

    // Backspace
    digit(4'd9); digit(4'd0); digit(4'd5);
    check("905_val", snap_val, 905);
    press(4'b0010, 4'd5);
    check("bk1_val", snap_val, 90);
    check("bk1_cnt", {28'd0, snap_cnt}, 2);
    press(4'b0010, 4'd5);
    check("bk2_val", snap_val, 9);
    check("bk2_cnt", {28'd0, snap_cnt}, 1);
    press(4'b0010, 4'd5);
    check("bk3_val", snap_val, 0);
    check("bk3_cnt", {28'd0, snap_cnt}, 0);
    check("bk3_state", {30'd0, snap_st}, 0);
    check("bk3_err", {31'd0, snap_ep}, 0);
    press(4'b0010, 4'd5);
    check("bk4_err", {31'd0, snap_ep}, 1);

    // Leading zero counts as a digit
    digit(4'd0);
    check("lz_val", snap_val, 0);
    check("lz_cnt", {28'd0, snap_cnt}, 1);
    check("lz_state", {30'd0, snap_st}, 1);
    press(4'b0100, 4'd0);

    // Enter in IDLE, invalid digit
    press(4'b1000, 4'd0);
    check("idle_ent_err", {31'd0, snap_ep}, 1);
    check("idle_ent_cp", {31'd0, snap_cp}, 0);
    check("idle_ent_cval", snap_cval, 12345678);
    digit(4'hC);
    check("badd_err", {31'd0, snap_ep}, 1);
    check("badd_cnt", {28'd0, snap_cnt}, 0);
    check("badd_val", snap_val, 0);

    // Bounce: 3-cycle highs never become an event
    sw_digit = 4'd3;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      btn_digit = 1'b1;
      repeat (3) @(negedge clk);
      btn_digit = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_cnt", {28'd0, digit_count}, 0);
    check("bounce_val", entry_value, 0);
    digit(4'd3);
    check("stable_val", snap_val, 3);
    check("stable_cnt", {28'd0, digit_count}, 1);

    // Clear beats enter
    press(4'b0100, 4'd0);
    digit(4'd5); digit(4'd6);
    check("56_val", snap_val, 56);
    press(4'b1100, 4'd6);
    check("ce_val", snap_val, 0);
    check("ce_cp", {31'd0, snap_cp}, 0);
    check("ce_err", {31'd0, snap_ep}, 0);
    check("ce_cval", snap_cval, 12345678);
    check("ce_state", {30'd0, snap_st}, 0);

    // Reset while in ENTRY
    digit(4'd1);
    check("pre_rst_state", {30'd0, state_out}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_val", entry_value, 0);
    check("mrst_cnt", {28'd0, digit_count}, 0);
    check("mrst_cval", commit_value, 0);
    check("mrst_state", {30'd0, state_out}, 0);
    check("mrst_pulses", {30'd0, commit_pulse, err_pulse}, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/amount_entry_encoder.md
Name: amount_entry_encoder

Overview:
- Keypad/switch entry front end for the ATM. The display decoder turns a binary balance into decimal digits; this block does the reverse.
- It turns debounced decimal digit presses into a 32-bit binary amount: value = value*10 + digit.
- It supports backspace, clear and enter. On enter it emits a one-cycle commit pulse with the latched amount to the transaction logic.
- The live entry value is exported so it can drive the 8-digit display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required before a synchronized button level is accepted (bench uses 4).
- MAX_DIGITS, 8, maximum decimal digits accepted (1..9). 99,999,999 fits in 32 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sw_digit  input  4  digit value on switches, sampled at the digit-press event
- btn_digit  input  1  raw push button: append sw_digit
- btn_back  input  1  raw push button: delete last digit
- btn_clear  input  1  raw push button: clear entry
- btn_enter  input  1  raw push button: commit entry
- entry_value  output  32  live binary value of the digits entered so far
- digit_count  output  4  number of digits currently held
- commit_value  output  32  amount latched at last commit; held until the next commit
- commit_pulse  output  1  one-cycle strobe, same cycle commit_value updates
- err_pulse  output  1  one-cycle strobe on a rejected action
- state_out  output  2  current FSM state (00 IDLE, 01 ENTRY), for debug/LEDs

Behaviour:
- Reset (rst high at a clk edge): every output and internal register goes to 0. This includes synchronizers, debounce counters, debounced levels and the FSM (IDLE). rst has priority over all events. Reset mid-debounce or mid-entry discards everything, with no commit or error pulse.
- Input conditioning, applied to each of the 4 buttons and to sw_digit:
  - 2-flop synchronizer.
  - Per-button debounce counter, cleared whenever the synchronized level equals the debounced level.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive differing samples.
  - An event is the debounced rising edge only; release is ignored.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Fixed latency: the first clk edge sampling a raw button high starts the count. Outputs update exactly DEBOUNCE_CYCLES+3 edges later (2 sync + DEBOUNCE_CYCLES + 1 action register).
- Simultaneous events in one cycle: only the highest priority is acted on; the others are dropped (no error). Priority is clear > enter > back > digit.
- FSM:
  - IDLE: digit_count=0 and entry_value=0.
  - ENTRY: digit_count ≥ 1.
- Digit event, with d = synchronized sw_digit:
  - If d > 9: err_pulse, no change.
  - Else if digit_count == MAX_DIGITS: err_pulse, no change.
  - Else: entry_value ← entry_value*10 + d and digit_count += 1; IDLE→ENTRY. A leading 0 counts as a digit: entry_value stays 0, digit_count increments, state is ENTRY.
- Back event:
  - In ENTRY: entry_value ← entry_value/10 (truncating) and digit_count −= 1. Go to IDLE when the count reaches 0.
  - In IDLE: err_pulse.
- Clear event: entry_value=0, digit_count=0, go to IDLE. No error even if already IDLE.
- Enter event:
  - In ENTRY: commit_value ← entry_value, commit_pulse=1 for exactly one cycle, then entry_value=0, digit_count=0, IDLE. All of this happens in the same clock.
  - In IDLE: err_pulse and no commit; commit_value unchanged.
- Arithmetic: the multiply-by-10 is done in 32 bits. It cannot overflow because MAX_DIGITS ≤ 9 bounds the value below 10^9.
- err_pulse and commit_pulse are never high in the same cycle. Each is high for exactly one cycle per qualifying event.
- Holding a button produces exactly one event. The next event requires a debounced release, then a press.

Test Plan:
- Reset, then press digit with sw_digit=4, then 2, then 7 (DEBOUNCE_CYCLES=4) → entry_value 4, 42, 427; digit_count 1, 2, 3. Each update lands exactly 7 cycles after its raw press.
- Enter 1,2,3,4,5,6,7,8, then a 9th digit press → the 9th gives err_pulse. entry_value=12345678. Enter → commit_pulse 1 cycle, commit_value=12345678, entry_value=0, state IDLE.
- Enter 9,0,5, back, back → entry_value 90 then 9, count 1. A third back gives 0/IDLE. A fourth back gives err_pulse.
- Enter in IDLE, and a digit press with sw_digit=4'hC → err_pulse each time, no commit; commit_value retains the previous amount.
- Bounce: btn_digit toggled high for 3 cycles then low, repeated 5 times → no event. Stable high afterwards → exactly one event.
- btn_clear and btn_enter rising together with entry_value=56 → clear wins: entry_value=0, no commit_pulse. Assert rst while in ENTRY → all outputs 0 the next cycle.
